// File: rtl/dmem_stall_ctrl_pkg.sv
// dmem_stall_ctrl_pkg
//   Shared definitions for the data-memory stall controller: FSM state
//   encodings, the latency ceiling supported by the wait counter, the
//   counter width and a saturating increment helper for the optional
//   performance counters.
package dmem_stall_ctrl_pkg;

  localparam int DATA_W       = 32;
  localparam int DMEM_LAT_MAX = 15;
  localparam int DMEM_CNT_W   = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_HOLD = 2'd2
  } dmem_state_e;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_perf_cnt.sv
// dmem_perf_cnt
//   Three saturating 32-bit event counters for the data-memory controller.
//   Only instantiated when DMEM_PERF_CNT_EN is defined.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears counters)
//   inc_load          one load completed this cycle
//   inc_store         one store issued this cycle
//   inc_stall         mem_stall asserted this cycle
//   perf_loads        completed-load count
//   perf_stores       issued-store count
//   perf_stall_cycles stalled-cycle count
module dmem_perf_cnt
  import dmem_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_load,
  input  logic        inc_store,
  input  logic        inc_stall,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall_cycles
);

  logic [31:0] loads_q,  loads_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    stalls_d = stalls_q;
    if (inc_load)  loads_d  = sat_inc32(loads_q);
    if (inc_store) stores_d = sat_inc32(stores_q);
    if (inc_stall) stalls_d = sat_inc32(stalls_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      stalls_q <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_loads        = loads_q;
  assign perf_stores       = stores_q;
  assign perf_stall_cycles = stalls_q;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl
//   Bridges the MEM stage of a 5-stage MIPS pipeline to a fixed-latency
//   synchronous single-port data RAM. Loads stall the pipeline for exactly
//   LATENCY cycles; stores are posted without stall; misaligned word
//   accesses are suppressed and flagged with a one-cycle mem_addr_err.
//   Optional feature macro: DMEM_PERF_CNT_EN (adds perf counter outputs).
// Parameters:
//   ADDR_WIDTH  word-address bits driven to the RAM
//   LATENCY     cycles from ram_en to valid ram_rdata (1..15)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid, mem_en         MEM-stage valid / advance
//   mem_ren, mem_wen          load / store request (both set => load)
//   mem_addr, mem_dout        byte address, store data
//   mem_din                   load data back to the pipeline
//   mem_stall                 hold IF..MEM while a load is outstanding
//   mem_addr_err              pulse on a misaligned access
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata   RAM port
//   perf_loads, perf_stores, perf_stall_cycles        (DMEM_PERF_CNT_EN only)
module dmem_stall_ctrl
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_en,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  mem_addr_err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_stall_cycles
`endif
);

  if (LATENCY < 1 || LATENCY > DMEM_LAT_MAX) begin : g_lat_chk
    $error("dmem_stall_ctrl: LATENCY must be in 1..15");
  end

  dmem_state_e            state_q, state_d;
  logic [DMEM_CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0]      rd_q,    rd_d;

  logic req;
  logic mis;
  logic load_done;

  // Only the word-address bits reach the RAM; the rest are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

  assign req       = mem_valid & (mem_ren | mem_wen);
  assign mis       = (mem_addr[1:0] != 2'b00);
  assign ram_addr  = mem_addr[ADDR_WIDTH+1:2];
  assign ram_wdata = mem_dout;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    mem_stall    = 1'b0;
    mem_addr_err = 1'b0;
    mem_din      = '0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    load_done    = 1'b0;

    // Everything is quiet while reset is held, so an in-flight read
    // can never leak onto mem_din or trigger new RAM traffic.
    if (!rst) begin
      unique case (state_q)
        DMEM_IDLE: begin
          if (req) begin
            if (mis) begin
              mem_addr_err = 1'b1;
            end else if (mem_ren) begin
              ram_en    = 1'b1;
              mem_stall = 1'b1;
              cnt_d     = DMEM_CNT_W'(LATENCY - 1);
              state_d   = DMEM_WAIT;
            end else begin
              ram_en = 1'b1;
              ram_we = 1'b1;
            end
          end
        end

        DMEM_WAIT: begin
          if (cnt_q != '0) begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q - 1'b1;
          end else begin
            // Bypass the RAM data in the completion cycle; keep a copy in
            // case another stall source holds the pipeline.
            load_done = 1'b1;
            mem_din   = ram_rdata;
            rd_d      = ram_rdata;
            state_d   = mem_en ? DMEM_IDLE : DMEM_HOLD;
          end
        end

        DMEM_HOLD: begin
          mem_din = rd_q;
          if (mem_en) state_d = DMEM_IDLE;
        end

        default: state_d = DMEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  dmem_perf_cnt u_perf (
    .clk               (clk),
    .rst               (rst),
    .inc_load          (load_done),
    .inc_store         (ram_we),
    .inc_stall         (mem_stall),
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule
